// File: rtl/accum_buffer_pkg.sv
// Shared helpers for the ping-pong accumulation buffer: default geometry and
// signed lane limits used by the saturating adder (ACCUM_BUF_SATURATE_EN).
package accum_buffer_pkg;

    localparam int DEF_LANE_WIDTH      = 32;
    localparam int DEF_NUM_LANES       = 2;
    localparam int DEF_BANK_ADDR_WIDTH = 9;
    localparam int DEF_BANK_DEPTH      = 200;

    // Lane limits are returned 64 bits wide; callers size-cast to their lane width.
    localparam int MAX_LANE_WIDTH = 64;

    function automatic logic [MAX_LANE_WIDTH-1:0] lane_min(input int unsigned width);
        lane_min = MAX_LANE_WIDTH'(1) << (width - 1);
    endfunction

    function automatic logic [MAX_LANE_WIDTH-1:0] lane_max(input int unsigned width);
        lane_max = (MAX_LANE_WIDTH'(1) << (width - 1)) - MAX_LANE_WIDTH'(1);
    endfunction

endpackage

// File: rtl/accum_buffer_rmw_lane_add.sv
// One signed accumulator lane: overwrite on init, otherwise add the operand.
// Build option ACCUM_BUF_SATURATE_EN clamps the add instead of wrapping.
module accum_lane_add
    import accum_buffer_pkg::*;
#(
    parameter int LANE_WIDTH = DEF_LANE_WIDTH
) (
    input  logic                  i_init,
    input  logic [LANE_WIDTH-1:0] i_old,
    input  logic [LANE_WIDTH-1:0] i_operand,
    output logic [LANE_WIDTH-1:0] o_result
);

    localparam int MSB = LANE_WIDTH - 1;

    logic [LANE_WIDTH-1:0] w_sum;
    logic [LANE_WIDTH-1:0] w_add;

    assign w_sum = i_old + i_operand;

`ifdef ACCUM_BUF_SATURATE_EN
    localparam logic [LANE_WIDTH-1:0] L_MAX = LANE_WIDTH'(lane_max(LANE_WIDTH));
    localparam logic [LANE_WIDTH-1:0] L_MIN = LANE_WIDTH'(lane_min(LANE_WIDTH));

    logic w_ovf;

    // Overflow only when both operands share a sign the sum does not.
    assign w_ovf = (i_old[MSB] == i_operand[MSB]) && (w_sum[MSB] != i_old[MSB]);
    assign w_add = w_ovf ? (i_old[MSB] ? L_MIN : L_MAX) : w_sum;
`else
    assign w_add = w_sum;
`endif

    assign o_result = i_init ? i_operand : w_add;

endmodule

// File: rtl/accum_buffer_rmw.sv
// Ping-pong accumulation buffer with an in-place read-modify-write pipeline on the
// accumulate bank and a 1-cycle read port on the writeback bank (ACCUM_BUF_SATURATE_EN).
module accum_buffer_rmw
    import accum_buffer_pkg::*;
#(
    parameter int LANE_WIDTH      = DEF_LANE_WIDTH,
    parameter int NUM_LANES       = DEF_NUM_LANES,
    parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH,
    parameter int BANK_DEPTH      = DEF_BANK_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            switch_banks,
    input  logic                            acc_en,
    input  logic                            acc_init,
    input  logic [BANK_ADDR_WIDTH-1:0]      acc_adr,
    input  logic [LANE_WIDTH*NUM_LANES-1:0] acc_data,
    output logic                            acc_busy,
    output logic                            acc_bank,
    input  logic                            ren_wb,
    input  logic [BANK_ADDR_WIDTH-1:0]      radr_wb,
    output logic [LANE_WIDTH*NUM_LANES-1:0] rdata_wb
);

    localparam int DATA_WIDTH = LANE_WIDTH * NUM_LANES;
    localparam int IDX_W      = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam logic [BANK_ADDR_WIDTH:0] DEPTH_LIM = (BANK_ADDR_WIDTH + 1)'(BANK_DEPTH);

    typedef struct packed {
        logic                  valid;
        logic                  bank;
        logic [IDX_W-1:0]      adr;
        logic [DATA_WIDTH-1:0] data;
    } s2_op_t;

    logic [DATA_WIDTH-1:0] r_bank0 [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] r_bank1 [BANK_DEPTH];

    logic                  r_bank_sel;
    s2_op_t                r_s2;
    logic                  r_s2_init;
    logic [DATA_WIDTH-1:0] r_s2_old;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_acc_ok;
    logic                  w_wb_ok;
    logic                  w_fwd;
    logic [IDX_W-1:0]      w_acc_idx;
    logic [IDX_W-1:0]      w_wb_idx;
    logic [DATA_WIDTH-1:0] w_mem_old;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_wb_word;
    logic [DATA_WIDTH-1:0] w_new;

    assign w_acc_ok  = acc_en && ({1'b0, acc_adr} < DEPTH_LIM);
    assign w_wb_ok   = ({1'b0, radr_wb} < DEPTH_LIM);
    assign w_acc_idx = acc_adr[IDX_W-1:0];
    assign w_wb_idx  = radr_wb[IDX_W-1:0];

    assign w_mem_old = r_bank_sel ? r_bank1[w_acc_idx] : r_bank0[w_acc_idx];
    assign w_wb_word = r_bank_sel ? r_bank0[w_wb_idx]  : r_bank1[w_wb_idx];

    // The word being written this cycle is not yet in the array; take it from stage 2.
    assign w_fwd = r_s2.valid && (r_s2.bank == r_bank_sel) && (r_s2.adr == w_acc_idx);
    assign w_old = w_fwd ? w_new : w_mem_old;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        accum_lane_add #(
            .LANE_WIDTH (LANE_WIDTH)
        ) u_lane_add (
            .i_init    (r_s2_init),
            .i_old     (r_s2_old[l*LANE_WIDTH +: LANE_WIDTH]),
            .i_operand (r_s2.data[l*LANE_WIDTH +: LANE_WIDTH]),
            .o_result  (w_new[l*LANE_WIDTH +: LANE_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_sel <= 1'b0;
            r_s2       <= '0;
            r_s2_init  <= 1'b0;
            r_s2_old   <= '0;
        end else begin
            if (switch_banks) begin
                r_bank_sel <= ~r_bank_sel;
            end
            r_s2.valid <= w_acc_ok;
            if (w_acc_ok) begin
                r_s2.bank <= r_bank_sel;
                r_s2.adr  <= w_acc_idx;
                r_s2.data <= acc_data;
                r_s2_init <= acc_init;
                r_s2_old  <= w_old;
            end
        end
    end

    // NOTE: the bank arrays are deliberately not reset; a reset only clears stage-2
    // valid, which is what aborts an in-flight write.
    always_ff @(posedge clk) begin
        if (r_s2.valid && !r_s2.bank) begin
            r_bank0[r_s2.adr] <= w_new;
        end
        if (r_s2.valid && r_s2.bank) begin
            r_bank1[r_s2.adr] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (ren_wb) begin
            r_rdata <= w_wb_ok ? w_wb_word : '0;
        end
    end

    assign acc_busy = r_s2.valid;
    assign acc_bank = r_bank_sel;
    assign rdata_wb = r_rdata;

endmodule

// File: tb/tb_accum_buffer_rmw.sv
// Self-checking bench for accum_buffer_rmw: directed cases plus randomized traffic
// against a delayed-commit array model (ACCUM_BUF_SATURATE_EN selects clamp vs wrap).
module tb_accum_buffer_rmw;

    localparam int LW    = 32;
    localparam int NL    = 2;
    localparam int AW    = 9;
    localparam int DEPTH = 200;
    localparam int DW    = LW * NL;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          switch_banks = 1'b0;
    logic          acc_en       = 1'b0;
    logic          acc_init     = 1'b0;
    logic [AW-1:0] acc_adr      = '0;
    logic [DW-1:0] acc_data     = '0;
    logic          ren_wb       = 1'b0;
    logic [AW-1:0] radr_wb      = '0;
    logic          acc_busy;
    logic          acc_bank;
    logic [DW-1:0] rdata_wb;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: latest values (what an accumulate sees) and committed values (what a
    // writeback read sees); an op becomes committed one cycle after it is issued.
    logic [DW-1:0] m_latest [2][DEPTH];
    logic [DW-1:0] m_commit [2][DEPTH];
    bit            m_def_latest [2][DEPTH];
    bit            m_def_commit [2][DEPTH];
    bit            m_sel;
    bit            p_v;
    bit            p_b;
    int            p_a;
    logic [DW-1:0] p_val;
    bit            p_def;
    logic [DW-1:0] exp_rd;
    bit            exp_rd_known;

    always #5 clk = ~clk;

    accum_buffer_rmw #(
        .LANE_WIDTH      (LW),
        .NUM_LANES       (NL),
        .BANK_ADDR_WIDTH (AW),
        .BANK_DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .switch_banks (switch_banks),
        .acc_en       (acc_en),
        .acc_init     (acc_init),
        .acc_adr      (acc_adr),
        .acc_data     (acc_data),
        .acc_busy     (acc_busy),
        .acc_bank     (acc_bank),
        .ren_wb       (ren_wb),
        .radr_wb      (radr_wb),
        .rdata_wb     (rdata_wb)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        longint        s;
        r = '0;
        for (int l = 0; l < NL; l++) begin
            s = longint'($signed(a[l*LW +: LW])) + longint'($signed(b[l*LW +: LW]));
`ifdef ACCUM_BUF_SATURATE_EN
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
            r[l*LW +: LW] = s[LW-1:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        if (p_v) begin
            m_def_latest[p_b][p_a] = 1'b0;
            m_def_commit[p_b][p_a] = 1'b0;
        end
        p_v          = 1'b0;
        m_sel        = 1'b0;
        exp_rd       = '0;
        exp_rd_known = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model at the edge and compare outputs.
    task automatic cycle(input logic sw, input logic en, input logic init,
                         input logic [AW-1:0] adr, input logic [DW-1:0] data,
                         input logic ren, input logic [AW-1:0] radr);
        int            ia;
        int            ir;
        logic [DW-1:0] nv;
        switch_banks = sw;
        acc_en       = en;
        acc_init     = init;
        acc_adr      = adr;
        acc_data     = data;
        ren_wb       = ren;
        radr_wb      = radr;
        @(posedge clk);
        ia = int'(adr);
        ir = int'(radr);
        if (ren) begin
            if (ir < DEPTH) begin
                exp_rd       = m_commit[int'(!m_sel)][ir];
                exp_rd_known = m_def_commit[int'(!m_sel)][ir];
            end else begin
                exp_rd       = '0;
                exp_rd_known = 1'b1;
            end
        end
        if (p_v) begin
            m_commit[p_b][p_a]     = p_val;
            m_def_commit[p_b][p_a] = p_def;
        end
        p_v = 1'b0;
        if (en && ia < DEPTH) begin
            nv    = init ? data : lane_add(m_latest[m_sel][ia], data);
            p_def = init ? 1'b1 : m_def_latest[m_sel][ia];
            m_latest[m_sel][ia]     = nv;
            m_def_latest[m_sel][ia] = p_def;
            p_v   = 1'b1;
            p_b   = m_sel;
            p_a   = ia;
            p_val = nv;
        end
        if (sw) m_sel = !m_sel;
        #1;
        check("acc_busy", 64'(acc_busy), 64'(p_v));
        check("acc_bank", 64'(acc_bank), 64'(m_sel));
        if (exp_rd_known) check("rdata_wb", rdata_wb, exp_rd);
    endtask

    initial begin
        logic [DW-1:0] exp_wrap;
`ifdef ACCUM_BUF_SATURATE_EN
        exp_wrap = 64'h7FFFFFFF_80000000;
`else
        exp_wrap = 64'h80000000_7FFFFFFF;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(acc_busy), 64'd0);
        check("rst_bank", 64'(acc_bank), 64'd0);
        check("rst_rdata", rdata_wb, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Init then add, read back after the swap.
        cycle(0, 1, 1, 9'd10, 64'h00000005_00000003, 0, 9'd0);
        cycle(0, 1, 0, 9'd10, 64'h00000001_00000002, 0, 9'd0);
        cycle(1, 0, 0, 9'd0, 64'd0, 0, 9'd0);
        cycle(0, 0, 0, 9'd0, 64'd0, 1, 9'd10);
        check("t1_sum", rdata_wb, 64'h00000006_00000005);

        // Back-to-back ops to one address exercise forwarding.
        cycle(0, 1, 1, 9'd20, 64'h00000001_00000001, 0, 9'd0);
        cycle(0, 1, 0, 9'd20, 64'h00000002_00000002, 0, 9'd0);
        cycle(0, 1, 0, 9'd20, 64'h00000003_00000003, 0, 9'd0);
        cycle(1, 0, 0, 9'd0, 64'd0, 0, 9'd0);
        cycle(0, 0, 0, 9'd0, 64'd0, 1, 9'd20);
        check("t2_fwd", rdata_wb, 64'h00000006_00000006);

        // Op on the switching edge lands in the new writeback bank one cycle late.
        cycle(0, 1, 1, 9'd30, 64'h11111111_22222222, 0, 9'd0);
        cycle(1, 1, 1, 9'd30, 64'hCAFE0000_0000BABE, 0, 9'd0);
        check("t3_bank", 64'(acc_bank), 64'd1);
        cycle(0, 0, 0, 9'd0, 64'd0, 1, 9'd30);
        check("t3_rd_t1", rdata_wb, 64'h11111111_22222222);
        cycle(0, 0, 0, 9'd0, 64'd0, 1, 9'd30);
        check("t3_rd_t2", rdata_wb, 64'hCAFE0000_0000BABE);

        // Lane overflow in both directions.
        cycle(0, 1, 1, 9'd40, 64'h7FFFFFFF_80000000, 0, 9'd0);
        cycle(0, 1, 0, 9'd40, 64'h00000001_FFFFFFFF, 0, 9'd0);
        cycle(1, 0, 0, 9'd0, 64'd0, 0, 9'd0);
        cycle(0, 0, 0, 9'd0, 64'd0, 1, 9'd40);
        check("t4_ovf", rdata_wb, exp_wrap);

        // Out-of-range accumulate and read.
        cycle(0, 1, 1, 9'd200, 64'hDEAD_BEEF, 0, 9'd0);
        check("t5_busy", 64'(acc_busy), 64'd0);
        cycle(0, 0, 0, 9'd0, 64'd0, 1, 9'd200);
        check("t5_rd", rdata_wb, 64'd0);

        // Reset while a write is in flight.
        cycle(0, 0, 0, 9'd0, 64'd0, 1, 9'd20);
        cycle(1, 1, 1, 9'd7, 64'h00001234_00005678, 0, 9'd0);
        check("t6_busy_pre", 64'(acc_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_busy", 64'(acc_busy), 64'd0);
        check("t6_bank", 64'(acc_bank), 64'd0);
        check("t6_rdata", rdata_wb, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 1, 1, 9'd5, 64'hA5A5A5A5_5A5A5A5A, 0, 9'd0);
        cycle(1, 0, 0, 9'd0, 64'd0, 0, 9'd0);
        cycle(0, 0, 0, 9'd0, 64'd0, 1, 9'd5);
        check("t6_after", rdata_wb, 64'hA5A5A5A5_5A5A5A5A);

        // Randomized traffic over a small address window for frequent collisions.
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a;
            logic [AW-1:0] ra;
            a  = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(195, 230))
                                              : AW'($urandom_range(0, 7));
            ra = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(195, 230))
                                              : AW'($urandom_range(0, 7));
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, a, {$urandom, $urandom},
                  $urandom_range(0, 1) == 1, ra);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
